mesh_inject_arbiter: RTL and testbench

//   Shares one node local-injection port of the mesh among NUM_REQ spike sources (neuron clusters).

---
 rtl/mesh_inject_arbiter_if.sv | 26 ++
 rtl/mesh_inject_arbiter.sv | 100 ++++++++++
 tb/tb_mesh_inject_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mesh_inject_arbiter_if.sv
// mesh_inject_arbiter_if: source request bus plus node injection port.
// slave = arbiter side, master = sources/node side.
interface mesh_inject_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         dout;
  logic                          vout;
  logic                          rin;
  logic [GW-1:0]                 grant_id;

  modport slave (
    input  req_data, req_valid, rin,
    output req_ready, dout, vout, grant_id
  );

  modport master (
    output req_data, req_valid, rin,
    input  req_ready, dout, vout, grant_id
  );
endinterface

// File: rtl/mesh_inject_arbiter.sv
// mesh_inject_arbiter: round-robin, burst-locked arbiter feeding one mesh injection port.
// Define INJ_STATS_EN to add the pkt_count/stall_count delivery counters.
module mesh_inject_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef INJ_STATS_EN
  output logic [31:0] pkt_count,
  output logic [31:0] stall_count,
`endif
  mesh_inject_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAXB = BW'(MAX_BURST);

  logic [IW-1:0] ptr, owner, scan_ptr, scan_idx, grant;
  logic [BW-1:0] burst_cnt;
  logic          lock, load_en, owner_ok, rel_lock;
  logic          found, any_valid, accept;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  assign load_en   = !bus.vout || bus.rin;
  assign any_valid = |bus.req_valid;
  assign owner_ok  = lock && bus.req_valid[owner] && (burst_cnt < MAXB);
  // Releasing the lock rescans from owner+1 in the same cycle.
  assign rel_lock  = lock && load_en && !owner_ok;
  assign scan_ptr  = rel_lock ? wrap_inc(owner) : ptr;
  assign grant     = owner_ok ? owner : scan_idx;
  assign accept    = load_en && any_valid && !rst;

  always_comb begin
    int idx;
    scan_idx = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(scan_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found    = 1'b1;
        scan_idx = IW'(idx);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dout     <= '0;
      bus.vout     <= 1'b0;
      bus.grant_id <= '0;
      ptr          <= '0;
      owner        <= '0;
      lock         <= 1'b0;
      burst_cnt    <= '0;
    end else begin
      if (rel_lock) begin
        lock <= 1'b0;
        ptr  <= wrap_inc(owner);
      end
      if (accept) begin
        bus.dout     <= bus.req_data[grant*DATA_WIDTH +: DATA_WIDTH];
        bus.vout     <= 1'b1;
        bus.grant_id <= grant;
        if (owner_ok) begin
          burst_cnt <= burst_cnt + 1'b1;
        end else begin
          owner     <= grant;
          lock      <= 1'b1;
          burst_cnt <= BW'(1);
        end
      end else if (bus.rin) begin
        bus.vout <= 1'b0;
      end
    end
  end

`ifdef INJ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count   <= '0;
      stall_count <= '0;
    end else begin
      if (bus.vout && bus.rin)  pkt_count   <= pkt_count + 1;
      if (bus.vout && !bus.rin) stall_count <= stall_count + 1;
    end
  end
`endif
endmodule

// File: tb/tb_mesh_inject_arbiter.sv
// tb_mesh_inject_arbiter: directed vectors with hand-computed expectations.
// NUM_REQ=4, DATA_WIDTH=32, MAX_BURST=4.
module tb_mesh_inject_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  mesh_inject_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

`ifdef INJ_STATS_EN
  logic [31:0] pkt_count, stall_count;
`endif

  mesh_inject_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef INJ_STATS_EN
    .pkt_count(pkt_count),
    .stall_count(stall_count),
`endif
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [31:0] v);
    bus.req_data[i*DW +: DW] = v;
  endtask

  task automatic out_is(input string tag, input int g,
                        input logic [31:0] d);
    check({tag, "_vout"}, bus.vout, 1);
    check({tag, "_gid"}, bus.grant_id, g);
    check({tag, "_dout"}, bus.dout, d);
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_data(i, 32'hD000_0000 + i);
    bus.req_valid = '1;
    bus.rin       = 1'b1;
    rst           = 1'b1;

    // reset with all sources valid
    step();
    step();
    check("rst_vout", bus.vout, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_gid", bus.grant_id, 0);
    check("rst_ready", bus.req_ready, 0);
    rst = 1'b0;
    #1;

    // burst rotation 0,0,0,0,1,1,1,1,2,2,2,2
    for (int n = 0; n < 12; n++) begin
      check("rot_ready", bus.req_ready, 4'b0001 << (n / 4));
      step();
      out_is("rot", n / 4, 32'hD000_0000 + n / 4);
    end

    // reset while a packet is pending
    rst = 1'b1;
    #1;
    check("rst2_ready", bus.req_ready, 0);
    step();
    check("rst2_vout", bus.vout, 0);
    check("rst2_dout", bus.dout, 0);
    rst = 1'b0;

    // single source 2, crosses a burst boundary
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      set_data(2, 32'hA5A5_0001 + k);
      #1;
      check("single_ready", bus.req_ready, 4'b0100);
      step();
      out_is("single", 2, 32'hA5A5_0001 + k);
    end

    // backpressure
    set_data(2, 32'h1234_5678);
    #1;
    step();
    out_is("bp_load", 2, 32'h1234_5678);
    bus.rin = 1'b0;
    set_data(2, 32'hDEAD_BEEF);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_ready", bus.req_ready, 0);
      step();
      out_is("bp_hold", 2, 32'h1234_5678);
    end
    bus.rin = 1'b1;
    #1;
    check("bp_reload", bus.req_ready, 4'b0100);
    step();
    out_is("bp_drain", 2, 32'hDEAD_BEEF);

    // early release: owner 1 drops after 2 packets
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_data(i, 32'hD000_0000 + i);
    bus.req_valid = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      step();
      out_is("er_own", 1, 32'hD000_0001);
    end
    bus.req_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("er_ready3", bus.req_ready, 4'b1000);
      step();
      out_is("er_src3", 3, 32'hD000_0003);
    end
    #1;
    check("er_ready0", bus.req_ready, 4'b0001);
    step();
    out_is("er_src0", 0, 32'hD000_0000);

    // nothing valid: slot drains, dout holds
    bus.req_valid = '0;
    #1;
    check("idle_ready", bus.req_ready, 0);
    step();
    check("idle_vout", bus.vout, 0);
    check("idle_dout", bus.dout, 32'hD000_0000);

`ifdef INJ_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("st_rst_pkt", pkt_count, 0);
    check("st_rst_stall", stall_count, 0);
    bus.req_valid = 4'b0001;
    bus.rin       = 1'b1;
    step();
    repeat (10) step();
    bus.rin = 1'b0;
    repeat (7) step();
    check("st_pkt", pkt_count, 10);
    check("st_stall", stall_count, 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("st_clr_pkt", pkt_count, 0);
    check("st_clr_stall", stall_count, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
